// File: rtl/sram_mc_pkg.sv
// Shared types and sizing helpers for the multi-channel SRAM.
package sram_mc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Number of byte lanes in a word.
  function automatic int be_width(input int width);
    return width / 8;
  endfunction

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_idx_width(input int num_ch);
    if (num_ch <= 1) begin
      return 1;
    end else begin
      return $clog2(num_ch);
    end
  endfunction

endpackage

// File: rtl/sram_mc_memory_rr_arbiter.sv
// Round-robin arbiter: the channel after the last winner has top priority.
module rr_arbiter
  import sram_mc_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CH-1:0]                 req,
  input  logic                              advance,
  output logic [NUM_CH-1:0]                 grant,
  output logic [ch_idx_width(NUM_CH)-1:0]   index
);

  localparam int IW = ch_idx_width(NUM_CH);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  // Scan channels starting at the pointer and pick the first requester.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_CH);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        index       = cand;
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Move priority past the winner, only when the grant is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (index == IW'(NUM_CH - 1)) ? '0 : index + IW'(1);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/sram_mc_memory.sv
// Multi-channel single-port SRAM with round-robin access, byte enables,
// wait states and out-of-range reporting. Storage stays reachable as mem.
module sram_mc_memory
  import sram_mc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ADDR_WIDTH  = 6,
  parameter int DEPTH       = 64,
  parameter int NUM_CH      = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            valid,
  input  logic [NUM_CH-1:0]            wr_en,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CH*WIDTH-1:0]      wdata,
  input  logic [NUM_CH*(WIDTH/8)-1:0]  be,
  output logic [NUM_CH*WIDTH-1:0]      rdata,
  output logic [NUM_CH-1:0]            ready,
  output logic [NUM_CH-1:0]            err
);

  localparam int                  BW        = be_width(WIDTH);
  localparam int                  IW        = ch_idx_width(NUM_CH);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  reg [WIDTH-1:0] mem [0:DEPTH-1];

  state_t                state;
  state_t                state_next;
  logic [NUM_CH-1:0]     grant;
  logic [IW-1:0]         gnt_idx;
  logic                  advance;
  logic                  sel_oor;
  logic [IW-1:0]         ch;
  logic                  cur_wr;
  logic                  cur_oor;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [WIDTH-1:0]      cur_wdata;
  logic [BW-1:0]         cur_be;
  logic [3:0]            wcnt;

  // Grants are only taken in IDLE, so RESP can never re-serve a stale request.
  assign advance = (state == IDLE) && (|grant);
  assign sel_oor = {1'b0, addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH]} >= DEPTH_LIM;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (valid),
    .advance (advance),
    .grant   (grant),
    .index   (gnt_idx)
  );

  // Next-state logic for the access sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (advance) begin
          state_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (wcnt == 4'd0) begin
          state_next = ACCESS;
        end else begin
          state_next = WAIT;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, request latch, wait counter and registered responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      cur_wr    <= 1'b0;
      cur_oor   <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cur_be    <= '0;
      wcnt      <= 4'd0;
      rdata     <= '0;
      ready     <= '0;
      err       <= '0;
    end else begin
      state <= state_next;
      ready <= '0;
      err   <= '0;
      case (state)
        IDLE: begin
          if (advance) begin
            ch        <= gnt_idx;
            cur_wr    <= wr_en[gnt_idx];
            cur_addr  <= addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            cur_wdata <= wdata[gnt_idx*WIDTH +: WIDTH];
            cur_be    <= be[gnt_idx*BW +: BW];
            cur_oor   <= sel_oor;
            wcnt      <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end
        end
        ACCESS: begin
          ready[ch] <= 1'b1;
          err[ch]   <= cur_oor;
          if (!cur_wr) begin
            rdata[ch*WIDTH +: WIDTH] <= cur_oor ? '0 : mem[cur_addr];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Byte-masked array write; out-of-range writes are dropped, no reset on storage.
  always_ff @(posedge clk) begin
    if (state == ACCESS && cur_wr && !cur_oor) begin
      for (int b = 0; b < BW; b++) begin
        if (cur_be[b]) begin
          mem[cur_addr][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_mc_memory.sv
// Self-checking bench: two instances (no wait states with a 48-word array,
// and three wait states with a 64-word array) against a word-level model.
module tb_sram_mc_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst3;
  logic [1:0]  valid0, wr_en0, ready0, err0;
  logic [11:0] addr0;
  logic [31:0] wdata0, rdata0;
  logic [3:0]  be0;
  logic [1:0]  valid3, wr_en3, ready3, err3;
  logic [11:0] addr3;
  logic [31:0] wdata3, rdata3;
  logic [3:0]  be3;

  sram_mc_memory #(.WIDTH(16), .ADDR_WIDTH(6), .DEPTH(48), .NUM_CH(2), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst0), .valid(valid0), .wr_en(wr_en0), .addr(addr0), .wdata(wdata0),
    .be(be0), .rdata(rdata0), .ready(ready0), .err(err0)
  );

  sram_mc_memory #(.WIDTH(16), .ADDR_WIDTH(6), .DEPTH(64), .NUM_CH(2), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst3), .valid(valid3), .wr_en(wr_en3), .addr(addr3), .wdata(wdata3),
    .be(be3), .rdata(rdata3), .ready(ready3), .err(err3)
  );

  int          total = 0;
  int          bad = 0;
  logic [15:0] ref_mem [0:47];
  logic [15:0] ref_rd [0:1];
  int          ptr_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One request on dut0 from an idle block; model updates the array and lanes.
  task automatic txn0(input int ch, input logic wr, input logic [5:0] a,
                      input logic [15:0] d, input logic [1:0] b);
    int          cnt;
    logic        exp_err;
    logic [15:0] nv;
    valid0 = 2'b00;
    valid0[ch] = 1'b1;
    wr_en0[ch] = wr;
    addr0[ch*6 +: 6] = a;
    wdata0[ch*16 +: 16] = d;
    be0[ch*2 +: 2] = b;
    cnt = 0;
    while (ready0 == 2'b00 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    exp_err = (a >= 6'd48);
    if (!exp_err) begin
      if (wr) begin
        nv = ref_mem[a];
        if (b[0]) nv[7:0] = d[7:0];
        if (b[1]) nv[15:8] = d[15:8];
        ref_mem[a] = nv;
      end else begin
        ref_rd[ch] = ref_mem[a];
      end
    end else if (!wr) begin
      ref_rd[ch] = 16'h0000;
    end
    ptr_m = (ch + 1) % 2;
    check("lat0", cnt, 32'd2);
    check("ready0", {30'd0, ready0}, 32'd1 << ch);
    check("err0", {30'd0, err0}, exp_err ? (32'd1 << ch) : 32'd0);
    check("rdata0", rdata0, {ref_rd[1], ref_rd[0]});
    valid0 = 2'b00;
    @(negedge clk);
    check("pulse0", {28'd0, err0, ready0}, 32'd0);
  endtask

  initial begin
    int          cnt, c, exp_ch, cyc;
    int          nleft [0:1];
    logic [5:0]  caddr [0:1];
    logic        quiet;
    logic [15:0] m7, m9;

    rst0 = 1'b1; rst3 = 1'b1;
    valid0 = 2'b00; wr_en0 = 2'b00; addr0 = 12'd0; wdata0 = 32'd0; be0 = 4'd0;
    valid3 = 2'b00; wr_en3 = 2'b00; addr3 = 12'd0; wdata3 = 32'd0; be3 = 4'd0;
    ptr_m = 0;
    ref_rd[0] = 16'h0000; ref_rd[1] = 16'h0000;
    for (int i = 0; i < 48; i++) begin
      ref_mem[i] = 16'($urandom);
      dut0.mem[i] = ref_mem[i];
    end
    m7 = 16'($urandom);
    m9 = 16'($urandom) | 16'h0001;
    dut3.mem[7] = m7;
    dut3.mem[9] = m9;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;

    // Reset state.
    check("rst_ready0", {30'd0, ready0}, 32'd0);
    check("rst_err0", {30'd0, err0}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_ready3", {30'd0, ready3}, 32'd0);
    check("rst_rdata3", rdata3, 32'd0);

    // Full-word write then read back on channel 0.
    txn0(0, 1'b1, 6'd5, 16'hBEEF, 2'b11);
    txn0(0, 1'b0, 6'd5, 16'h0000, 2'b00);
    check("beef", {16'd0, rdata0[15:0]}, 32'h0000BEEF);

    // Upper-byte write on channel 1, then an all-disabled write.
    ref_mem[3] = 16'h1234;
    dut0.mem[3] = 16'h1234;
    txn0(1, 1'b1, 6'd3, 16'hAB00, 2'b10);
    check("mem3_be10", {16'd0, dut0.mem[3]}, 32'h0000AB34);
    txn0(1, 1'b1, 6'd3, 16'h5555, 2'b00);
    check("mem3_be00", {16'd0, dut0.mem[3]}, 32'h0000AB34);

    // Out-of-range write and read.
    txn0(0, 1'b1, 6'd50, 16'hCAFE, 2'b11);
    txn0(0, 1'b0, 6'd50, 16'h0000, 2'b00);

    // Both channels competing with four reads each.
    for (int k = 0; k < 2; k++) begin
      nleft[k] = 4;
      caddr[k] = 6'($urandom_range(0, 47));
      addr0[k*6 +: 6] = caddr[k];
    end
    wr_en0 = 2'b00;
    valid0 = 2'b11;
    cyc = 0;
    while ((nleft[0] + nleft[1]) > 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ready0 != 2'b00) begin
        exp_ch = valid0[ptr_m] ? ptr_m : 1 - ptr_m;
        check("arb_grant", {30'd0, ready0}, 32'd1 << exp_ch);
        c = ready0[1] ? 1 : 0;
        ref_rd[c] = ref_mem[caddr[c]];
        check("arb_rdata", rdata0, {ref_rd[1], ref_rd[0]});
        check("arb_err", {30'd0, err0}, 32'd0);
        ptr_m = (c + 1) % 2;
        nleft[c]--;
        if (nleft[c] > 0) begin
          caddr[c] = 6'($urandom_range(0, 47));
          addr0[c*6 +: 6] = caddr[c];
        end else begin
          valid0[c] = 1'b0;
        end
      end
    end
    check("arb_done", nleft[0] + nleft[1], 32'd0);
    valid0 = 2'b00;
    @(negedge clk);
    check("arb_idle", {30'd0, ready0}, 32'd0);

    // Random single transactions, including out-of-range addresses.
    repeat (30) begin
      txn0(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 55)),
           16'($urandom), 2'($urandom));
    end
    for (int i = 0; i < 48; i++) begin
      check("mem_sweep", {16'd0, dut0.mem[i]}, {16'd0, ref_mem[i]});
    end

    // Three wait states: single read, nothing visible before ready.
    valid3 = 2'b01; wr_en3 = 2'b00; addr3[5:0] = 6'd9;
    cnt = 0; quiet = 1'b1;
    while (ready3 == 2'b00 && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (ready3 == 2'b00 && (rdata3 != 32'd0 || err3 != 2'b00)) quiet = 1'b0;
    end
    check("ws3_lat", cnt, 32'd5);
    check("ws3_quiet", {31'd0, quiet}, 32'd1);
    check("ws3_ready", {30'd0, ready3}, 32'd1);
    check("ws3_rdata", rdata3, {16'h0000, m9});
    check("ws3_err", {30'd0, err3}, 32'd0);
    valid3 = 2'b00;
    @(negedge clk);
    check("ws3_pulse", {30'd0, ready3}, 32'd0);

    // Reset while a write to addr 7 is in its wait phase.
    valid3 = 2'b10; wr_en3 = 2'b10; addr3[11:6] = 6'd7; wdata3[31:16] = ~m7; be3 = 4'b1100;
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b1;
    #1;
    check("rst_mid_ready", {30'd0, ready3}, 32'd0);
    check("rst_mid_rdata", rdata3, 32'd0);
    @(negedge clk);
    valid3 = 2'b00; wr_en3 = 2'b00;
    rst3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_no_ready", {30'd0, ready3}, 32'd0);
    end
    check("rst_mem7", {16'd0, dut3.mem[7]}, {16'd0, m7});

    // Normal service after the reset.
    valid3 = 2'b10; addr3[11:6] = 6'd7;
    cnt = 0;
    while (ready3 == 2'b00 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("post_rst_lat", cnt, 32'd5);
    check("post_rst_ready", {30'd0, ready3}, 32'd2);
    check("post_rst_rdata", rdata3, {m7, 16'h0000});
    valid3 = 2'b00;
    @(negedge clk);
    check("post_rst_pulse", {30'd0, ready3}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
